sync_fifo_pro: RTL and testbench
================================

Name: sync_fifo_pro

Overview:
Parametrised single-clock FIFO, successor to the basic data-counter FIFO.
- Adds runtime-programmable almost-full/almost-empty thresholds, an occupancy count output, and a synchronous flush.
- Adds sticky overflow/underflow error flags and a selectable read mode: show-ahead or registered output.
- Used as the general buffering element between streaming producers and consumers in the datapath.

Parameters:
DATA_W, 32, data width in bits (>=1)
DEPTH, 16, number of entries (>=2, any integer, power of two not required)
SHOW_AHEAD, 1, 1 = head word visible combinationally on rd_data; 0 = registered read, data one cycle after accepted rd_en
CNT_W, $clog2(DEPTH+1), width of count and threshold ports (derived, not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous active-low reset
flush  in  1  synchronous flush, empties FIFO
wr_en  in  1  write request
wr_data  in  DATA_W  write data
full  out  1  count == DEPTH
almst_full  out  1  count >= upp_th
rd_en  in  1  read request
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data qualifier
empty  out  1  count == 0
almst_empty  out  1  count <= low_th
upp_th  in  CNT_W  almost-full threshold, quasi-static
low_th  in  CNT_W  almost-empty threshold, quasi-static
count  out  CNT_W  current occupancy
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
err_clr  in  1  clears overflow/underflow

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous deassert handled upstream): wrptr=rdptr=0, count=0, overflow=underflow=0, rd_valid=0, registered rd_data=0.
  - Memory array is not reset.
  - Reset mid-operation discards all contents immediately.
- Accept rules:
  - wr_acc = wr_en & !full & !flush.
  - rd_acc = rd_en & !empty & !flush.
  - Full/empty are evaluated on the registered count, so a write while full is rejected even with a simultaneous read, and a read while empty is rejected even with a simultaneous write.
- Pointers: increment on accept; wrap from DEPTH-1 to 0 (explicit compare, valid for non-power-of-two DEPTH).
- count:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
  - Never exceeds DEPTH or goes below 0.
- Flags:
  - full, empty, almst_full and almst_empty are combinational from the registered count and the threshold ports.
  - upp_th=0 forces almst_full=1; low_th>=DEPTH forces almst_empty=1.
- SHOW_AHEAD=1:
  - rd_data = mem[rdptr] combinationally; rd_valid = !empty.
  - rd_en pops the word currently shown.
  - rd_data is don't-care when rd_valid=0.
- SHOW_AHEAD=0:
  - On rd_acc, rd_data <= mem[rdptr] at that edge, and rd_valid=1 for the following cycle only.
  - Read latency is 1 cycle.
  - rd_data holds its last value when no read occurs; rd_valid=0 otherwise.
- Same-cycle write/read at count==1 (SHOW_AHEAD=0): the read returns the old head; the new word lands behind it.
- Errors:
  - overflow <= 1 on (wr_en & full & !flush); underflow <= 1 on (rd_en & empty & !flush).
  - Both hold until err_clr=1.
  - A set condition in the same cycle as err_clr wins (flag stays 1).
- Flush:
  - At the edge: wrptr=rdptr=count=0, rd_valid=0; wr_en/rd_en that cycle are ignored and do not raise error flags.
  - overflow/underflow are unchanged by flush.
- Threshold ports are sampled continuously; changing them changes almst_* in the same cycle, with no pipeline.

Test Plan:
1. DEPTH=8, upp_th=6, low_th=1; reset, then write 0x11..0x18 (8 words) -> count rises 1..8. almst_empty clears once count=2, almst_full sets once count=6, full=1 at count=8.
2. Full FIFO, wr_en=1 with wr_data=0xAA for 1 cycle -> count stays 8, overflow=1 and stays 1. Drain 8 words (SHOW_AHEAD=1) -> read order 0x11..0x18, empty=1. err_clr pulse -> overflow=0.
3. SHOW_AHEAD=0, 3 words 0xA,0xB,0xC queued; rd_en for 3 cycles -> rd_valid=1 on cycles 1..3 after the first rd_en, with data 0xA,0xB,0xC; rd_valid=0 on cycle 4.
4. DEPTH=5 (non-power-of-two): 20 cycles of simultaneous write/read with count held at 3 -> pointers wrap correctly, data returned in order, count stays 3, no error flags.
5. Empty FIFO, rd_en=1 -> underflow=1, count=0. Same cycle as a second underflow, assert err_clr -> underflow stays 1.
6. count=4, flush=1 with wr_en=rd_en=1 -> next cycle count=0, empty=1, rd_valid=0, no error flags set. Assert reset mid-burst -> all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/sync_fifo_pro.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, occupancy count,
// synchronous flush, sticky overflow/underflow flags and show-ahead or registered read output.
module sync_fifo_pro #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 16,
    parameter int SHOW_AHEAD = 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almst_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              almst_empty,
    input  logic [CNT_W-1:0]  upp_th,
    input  logic [CNT_W-1:0]  low_th,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // Handshake: a write is taken at the rising edge when wr_en=1, full=0 and flush=0.
    // Show-ahead: rd_valid=1 presents the head word; rd_en=1 while rd_valid=1 pops it.
    // Registered: an accepted rd_en returns the word with rd_valid=1 on the next cycle only.

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign full   = (count == DEPTH_CNT);
    assign empty  = (count == '0);
    assign wr_acc = wr_en && !full && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    // Thresholds act immediately; the explicit terms cover the forced cases.
    assign almst_full  = (upp_th == '0) || (count >= upp_th);
    assign almst_empty = (low_th >= DEPTH_CNT) || (count <= low_th);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A new error event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full && !flush) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty && !flush) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            assign rd_data  = mem[rd_ptr];
            assign rd_valid = !empty;
        end else begin : g_registered
            // rd_acc is already low during flush, which also clears rd_valid.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) begin
                        rd_data <= mem[rd_ptr];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Bench for sync_fifo_pro: a show-ahead DEPTH=8 instance and a registered-read DEPTH=5
// instance, each checked against a queue-based reference model plus directed sequences.
module tb_sync_fifo_pro;

    localparam int DW = 8;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_rd;
        logic [3:0]    exp_cnt;
        logic          exp_ae;
        logic          exp_af;
        logic          exp_full;
        logic          exp_ovf;
    } vec_t;

    logic                clk;
    logic                reset;
    logic [1:0]          flush;
    logic [1:0]          wr_en;
    logic [1:0]          rd_en;
    logic [1:0]          err_clr;
    logic [1:0][DW-1:0]  wr_data;
    logic [1:0][3:0]     upp_th;
    logic [1:0][3:0]     low_th;

    logic          full0, af0, ae0, empty0, rv0, ovf0, udf0;
    logic          full1, af1, ae1, empty1, rv1, ovf1, udf1;
    logic [DW-1:0] rd_data0, rd_data1;
    logic [3:0]    count0;
    logic [2:0]    count1;

    logic [1:0]         full_o, af_o, ae_o, empty_o, rv_o, ovf_o, udf_o;
    logic [1:0][DW-1:0] rd_data_o;
    logic [1:0][3:0]    count_o;

    assign full_o    = {full1, full0};
    assign af_o      = {af1, af0};
    assign ae_o      = {ae1, ae0};
    assign empty_o   = {empty1, empty0};
    assign rv_o      = {rv1, rv0};
    assign ovf_o     = {ovf1, ovf0};
    assign udf_o     = {udf1, udf0};
    assign rd_data_o = {rd_data1, rd_data0};
    assign count_o   = {{1'b0, count1}, count0};

    sync_fifo_pro #(.DATA_W(DW), .DEPTH(8), .SHOW_AHEAD(1)) u_sa (
        .clk(clk), .reset(reset), .flush(flush[0]),
        .wr_en(wr_en[0]), .wr_data(wr_data[0]), .full(full0), .almst_full(af0),
        .rd_en(rd_en[0]), .rd_data(rd_data0), .rd_valid(rv0), .empty(empty0),
        .almst_empty(ae0), .upp_th(upp_th[0]), .low_th(low_th[0]), .count(count0),
        .overflow(ovf0), .underflow(udf0), .err_clr(err_clr[0])
    );

    sync_fifo_pro #(.DATA_W(DW), .DEPTH(5), .SHOW_AHEAD(0)) u_reg (
        .clk(clk), .reset(reset), .flush(flush[1]),
        .wr_en(wr_en[1]), .wr_data(wr_data[1]), .full(full1), .almst_full(af1),
        .rd_en(rd_en[1]), .rd_data(rd_data1), .rd_valid(rv1), .empty(empty1),
        .almst_empty(ae1), .upp_th(upp_th[1][2:0]), .low_th(low_th[1][2:0]), .count(count1),
        .overflow(ovf1), .underflow(udf1), .err_clr(err_clr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    logic [1:0]    m_ovf, m_udf;
    logic          m_rv1;
    logic [DW-1:0] m_rdata1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    vec_t tbl[17];

    function automatic int dep(input int i);
        return (i == 0) ? 8 : 5;
    endfunction

    function automatic int msize(input int i);
        return (i == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        exp_q0.delete();
        exp_q1.delete();
        m_ovf    = '0;
        m_udf    = '0;
        m_rv1    = 1'b0;
        m_rdata1 = '0;
    endtask

    task automatic idle(input int i);
        flush[i]   = 1'b0;
        wr_en[i]   = 1'b0;
        rd_en[i]   = 1'b0;
        err_clr[i] = 1'b0;
        wr_data[i] = '0;
    endtask

    // Applies one clock edge of FIFO rules to the model using the inputs held before the edge.
    task automatic model_edge(input int i);
        int            n;
        logic          mfull, mempty, wa, ra;
        logic [DW-1:0] head;
        n      = msize(i);
        mfull  = (n == dep(i));
        mempty = (n == 0);
        wa     = wr_en[i] && !mfull && !flush[i];
        ra     = rd_en[i] && !mempty && !flush[i];
        if (wr_en[i] && mfull && !flush[i]) m_ovf[i] = 1'b1;
        else if (err_clr[i])                 m_ovf[i] = 1'b0;
        if (rd_en[i] && mempty && !flush[i]) m_udf[i] = 1'b1;
        else if (err_clr[i])                 m_udf[i] = 1'b0;
        if (flush[i]) begin
            if (i == 0) exp_q0.delete(); else exp_q1.delete();
            if (i == 1) m_rv1 = 1'b0;
        end else begin
            if (i == 1) m_rv1 = ra;
            if (ra) begin
                head = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                if (i == 1) m_rdata1 = head;
            end
            if (wa) begin
                if (i == 0) exp_q0.push_back(wr_data[i]); else exp_q1.push_back(wr_data[i]);
            end
        end
    endtask

    task automatic check_outputs(input int i);
        int n;
        n = msize(i);
        check($sformatf("count%0d", i), count_o[i], n);
        check($sformatf("full%0d", i), full_o[i], n == dep(i));
        check($sformatf("empty%0d", i), empty_o[i], n == 0);
        check($sformatf("almst_full%0d", i), af_o[i], (upp_th[i] == 0) || (n >= upp_th[i]));
        check($sformatf("almst_empty%0d", i), ae_o[i], (low_th[i] >= dep(i)) || (n <= low_th[i]));
        check($sformatf("overflow%0d", i), ovf_o[i], m_ovf[i]);
        check($sformatf("underflow%0d", i), udf_o[i], m_udf[i]);
        if (i == 0) begin
            check("rd_valid0", rv_o[0], n != 0);
            if (n != 0) check("rd_data0", rd_data_o[0], exp_q0[0]);
        end else begin
            check("rd_valid1", rv_o[1], m_rv1);
            check("rd_data1", rd_data_o[1], m_rdata1);
        end
    endtask

    task automatic step(input int i);
        @(posedge clk);
        model_edge(i);
        #1;
        check_outputs(i);
    endtask

    initial begin
        int wp;
        tbl[0]  = '{1'b1, 1'b0, 8'h11, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h12, 8'h00, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h13, 8'h00, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h14, 8'h00, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h15, 8'h00, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'h16, 8'h00, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h17, 8'h00, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h18, 8'h00, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'hAA, 8'h00, 4'd8, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, 8'h11, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 8'h12, 4'd6, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 8'h00, 8'h13, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 8'h00, 8'h14, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 8'h00, 8'h15, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 8'h00, 8'h16, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 8'h00, 8'h17, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 8'h00, 8'h18, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};

        reset = 1'b0;
        idle(0);
        idle(1);
        upp_th[0] = 4'd6; low_th[0] = 4'd1;
        upp_th[1] = 4'd4; low_th[1] = 4'd1;
        model_reset();
        #12;
        check_outputs(0);
        check_outputs(1);
        @(negedge clk);
        reset = 1'b1;

        // Fill to full, overflow attempt, drain in order
        for (int k = 0; k < 17; k++) begin
            wr_en[0]   = tbl[k].wr;
            rd_en[0]   = tbl[k].rd;
            wr_data[0] = tbl[k].wd;
            if (tbl[k].rd) check("tbl_rd_data", rd_data_o[0], tbl[k].exp_rd);
            step(0);
            check("tbl_count", count_o[0], tbl[k].exp_cnt);
            check("tbl_almst_empty", ae_o[0], tbl[k].exp_ae);
            check("tbl_almst_full", af_o[0], tbl[k].exp_af);
            check("tbl_full", full_o[0], tbl[k].exp_full);
            check("tbl_overflow", ovf_o[0], tbl[k].exp_ovf);
        end
        idle(0);
        err_clr[0] = 1'b1;
        step(0);
        check("err_clr_overflow", ovf_o[0], 0);
        check("drained_empty", empty_o[0], 1);
        err_clr[0] = 1'b0;

        // Underflow, and set-over-clear priority
        rd_en[0] = 1'b1;
        step(0);
        check("underflow_set", udf_o[0], 1);
        check("underflow_count", count_o[0], 0);
        err_clr[0] = 1'b1;
        step(0);
        check("underflow_set_wins", udf_o[0], 1);
        rd_en[0] = 1'b0;
        step(0);
        check("underflow_cleared", udf_o[0], 0);
        idle(0);

        // Threshold changes act without a clock edge, then flush with wr/rd asserted
        wr_en[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_data[0] = 8'(8'h40 + k);
            step(0);
        end
        idle(0);
        upp_th[0] = 4'd4; #1; check("th_af_at4", af_o[0], 1);
        upp_th[0] = 4'd5; #1; check("th_af_at5", af_o[0], 0);
        low_th[0] = 4'd4; #1; check("th_ae_at4", ae_o[0], 1);
        low_th[0] = 4'd3; #1; check("th_ae_at3", ae_o[0], 0);
        upp_th[0] = 4'd0; #1; check("th_af_zero", af_o[0], 1);
        low_th[0] = 4'd8; #1; check("th_ae_depth", ae_o[0], 1);
        upp_th[0] = 4'd6; low_th[0] = 4'd1;
        flush[0] = 1'b1; wr_en[0] = 1'b1; rd_en[0] = 1'b1; wr_data[0] = 8'h99;
        step(0);
        check("flush_count", count_o[0], 0);
        check("flush_empty", empty_o[0], 1);
        check("flush_rd_valid", rv_o[0], 0);
        check("flush_no_ovf", ovf_o[0], 0);
        check("flush_no_udf", udf_o[0], 0);
        idle(0);

        // Registered read latency
        wr_en[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr_data[1] = 8'(8'h0A + k);
            step(1);
        end
        wr_en[1] = 1'b0;
        rd_en[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("reg_rd_valid", rv_o[1], 1);
            check("reg_rd_data", rd_data_o[1], 8'h0A + k);
        end
        rd_en[1] = 1'b0;
        step(1);
        check("reg_rd_valid_drop", rv_o[1], 0);
        check("reg_rd_data_hold", rd_data_o[1], 8'h0C);

        // Non-power-of-two wrap with steady occupancy of 3
        wr_en[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr_data[1] = 8'(8'h20 + k);
            step(1);
        end
        rd_en[1] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wr_data[1] = 8'(8'h23 + k);
            step(1);
            check("wrap_count", count_o[1], 3);
            check("wrap_rd_data", rd_data_o[1], 8'h20 + k);
            check("wrap_no_ovf", ovf_o[1], 0);
            check("wrap_no_udf", udf_o[1], 0);
        end
        flush[1] = 1'b1;
        step(1);
        check("reg_flush_rd_valid", rv_o[1], 0);
        check("reg_flush_count", count_o[1], 0);
        idle(1);

        // Randomized traffic: fill-biased, drain-biased, then balanced phases
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 400; c++) begin
                wp = (c < 100) ? 80 : (c < 200) ? 20 : 50;
                if (c % 50 == 0) begin
                    upp_th[i] = 4'($urandom_range(0, dep(i)));
                    low_th[i] = 4'($urandom_range(0, dep(i)));
                end
                wr_en[i]   = ($urandom_range(0, 99) < wp);
                rd_en[i]   = ($urandom_range(0, 99) < (100 - wp));
                flush[i]   = ($urandom_range(0, 99) < 2);
                err_clr[i] = ($urandom_range(0, 99) < 4);
                wr_data[i] = 8'($urandom);
                step(i);
            end
            idle(i);
        end

        // Asynchronous reset in the middle of a write burst
        wr_en[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr_data[0] = 8'(8'h70 + k);
            step(0);
        end
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs(0);
        check_outputs(1);
        idle(0);
        @(negedge clk);
        reset = 1'b1;
        step(0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
